// File: rtl/fas_frame_scheduler.sv
// fas_frame_scheduler
//   Sequences the FAS datapath. FIR samples are packed into NPT-sample
//   frames in two ping-pong banks. Each full frame is offered to the FFT
//   engine, and the FFT results are counted. When the last result of the run
//   has returned, the analysis stage is started and the block waits for
//   analysis to finish before raising done.
//
// Optional feature (macro FAS_SCHED_TIMEOUT_EN):
//   This feature adds a watchdog that runs in DRAIN and ANALYZE. When it
//   expires, the FSM jumps to DONE and raises the sticky timeout output.
//   When the macro is undefined, there is no watchdog and no timeout port.
//
// Ports
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous reset, active-low
//   fir_valid  in   fir_d carries a valid sample this cycle
//   fir_d      in   [DW-1:0] FIR sample
//   frm_valid  out  a frame is offered to the FFT engine
//   frm_data   out  [DW*NPT-1:0] frame, sample n at [n*DW +: DW]
//   fft_ready  in   FFT engine accepts the frame when high with frm_valid
//   fft_valid  in   one-cycle pulse per FFT frame result
//   ana_start  out  one-cycle pulse starting the analysis stage
//   ana_done   in   analysis finished (pulse or level)
//   busy       out  high in RUN, DRAIN and ANALYZE
//   done       out  run complete, held until reset
//   overrun    out  sticky, a sample was dropped because its bank was full
//   dbg_state  out  current FSM state encoding, for observation
//   timeout    out  sticky watchdog expiry (FAS_SCHED_TIMEOUT_EN only)
//
// Handshake: a frame moves on a rising edge where frm_valid && fft_ready are
// both high. While frm_valid is high, frm_data is held stable until that
// edge. frm_valid never depends on fft_ready in the same cycle.
module fas_frame_scheduler #(
    parameter int DW         = 16,
    parameter int NPT        = 16,
    parameter int NUM_FRAMES = 64
`ifdef FAS_SCHED_TIMEOUT_EN
    , parameter int TIMEOUT  = 4096
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fir_valid,
    input  logic [DW-1:0]     fir_d,
    output logic              frm_valid,
    output logic [DW*NPT-1:0] frm_data,
    input  logic              fft_ready,
    input  logic              fft_valid,
    output logic              ana_start,
    input  logic              ana_done,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [2:0]        dbg_state
`ifdef FAS_SCHED_TIMEOUT_EN
    , output logic            timeout
`endif
);

    localparam int PW    = $clog2(NPT);
    localparam int TOTAL = NUM_FRAMES * NPT;
    localparam int SCW   = $clog2(TOTAL + 1);
    localparam int FCW   = $clog2(NUM_FRAMES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_DRAIN   = 3'd2,
        S_ANALYZE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                wr_bank_q, wr_bank_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]          full_q, full_d;
    logic                rd_bank_q, rd_bank_d;
    logic                frm_valid_q, frm_valid_d;
    logic [DW*NPT-1:0]   frm_data_q, frm_data_d;
    logic [SCW-1:0]      smp_cnt_q, smp_cnt_d;
    logic [FCW-1:0]      issued_q, issued_d;
    logic [FCW-1:0]      results_q, results_d;
    logic                overrun_q, overrun_d;
    logic                ana_start_q, ana_start_d;

    logic [DW-1:0]       bank_q [2][NPT];
    logic [DW*NPT-1:0]   bank_flat [2];

    logic                smp_take;
    logic                smp_acc;
    logic                smp_drop;
    logic                xfer;
    logic                rd_other;

`ifdef FAS_SCHED_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0]       wdog_q, wdog_d;
    logic                timeout_q, timeout_d;
`endif

    // Sample storage carries no reset: validity lives in full_q, so stale
    // contents are never presented.
    always_ff @(posedge clk) begin
        if (smp_acc) begin
            bank_q[wr_bank_q][wr_ptr_q] <= fir_d;
        end
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            for (int n = 0; n < NPT; n++) begin
                bank_flat[b][n*DW +: DW] = bank_q[b][n];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        wr_ptr_d    = wr_ptr_q;
        full_d      = full_q;
        rd_bank_d   = rd_bank_q;
        frm_valid_d = frm_valid_q;
        frm_data_d  = frm_data_q;
        smp_cnt_d   = smp_cnt_q;
        issued_d    = issued_q;
        results_d   = results_q;
        overrun_d   = overrun_q;
        ana_start_d = 1'b0;
        rd_other    = ~rd_bank_q;

        // Samples are taken only while collecting. The drop decision uses
        // the registered full flag, so a bank freed on this same edge still
        // counts as full.
        smp_take = fir_valid && (state_q == S_IDLE || state_q == S_RUN);
        smp_drop = smp_take && full_q[wr_bank_q];
        smp_acc  = smp_take && !full_q[wr_bank_q];
        xfer     = frm_valid_q && fft_ready;

        if (smp_acc) begin
            smp_cnt_d = smp_cnt_q + SCW'(1);
            if (wr_ptr_q == PW'(NPT - 1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_ptr_d          = '0;
            end else begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
        end
        if (smp_drop) begin
            overrun_d = 1'b1;
        end

        // The bank being written is never the one on offer (an offered bank
        // is full), so the set above and the clear below never collide.
        if (xfer) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = rd_other;
            if (issued_q != FCW'(NUM_FRAMES)) begin
                issued_d = issued_q + FCW'(1);
            end
            if (full_q[rd_other]) begin
                frm_valid_d = 1'b1;
                frm_data_d  = bank_flat[rd_other];
            end else begin
                frm_valid_d = 1'b0;
            end
        end else if (!frm_valid_q && full_q[rd_bank_q]) begin
            frm_valid_d = 1'b1;
            frm_data_d  = bank_flat[rd_bank_q];
        end

        // A result with nothing outstanding is spurious and is not counted.
        if (fft_valid && (results_q != issued_q)) begin
            results_d = results_q + FCW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (smp_acc) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (smp_acc && (smp_cnt_q == SCW'(TOTAL - 1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (results_q == FCW'(NUM_FRAMES)) begin
                    state_d     = S_ANALYZE;
                    ana_start_d = 1'b1;
                end
            end
            S_ANALYZE: begin
                if (ana_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef FAS_SCHED_TIMEOUT_EN
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        // The count restarts on any state change and on each FFT result
        // while draining. It expires after TIMEOUT cycles without progress.
        if ((state_q == S_DRAIN || state_q == S_ANALYZE) && (state_d == state_q)) begin
            if (state_q == S_DRAIN && fft_valid) begin
                wdog_d = '0;
            end else if (wdog_q == WW'(TIMEOUT - 1)) begin
                state_d   = S_DONE;
                timeout_d = 1'b1;
            end else begin
                wdog_d = wdog_q + WW'(1);
            end
        end else begin
            wdog_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            full_q      <= '0;
            rd_bank_q   <= 1'b0;
            frm_valid_q <= 1'b0;
            frm_data_q  <= '0;
            smp_cnt_q   <= '0;
            issued_q    <= '0;
            results_q   <= '0;
            overrun_q   <= 1'b0;
            ana_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            full_q      <= full_d;
            rd_bank_q   <= rd_bank_d;
            frm_valid_q <= frm_valid_d;
            frm_data_q  <= frm_data_d;
            smp_cnt_q   <= smp_cnt_d;
            issued_q    <= issued_d;
            results_q   <= results_d;
            overrun_q   <= overrun_d;
            ana_start_q <= ana_start_d;
        end
    end

`ifdef FAS_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`endif

    assign frm_valid = frm_valid_q;
    assign frm_data  = frm_data_q;
    assign ana_start = ana_start_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_ANALYZE);
    assign done      = (state_q == S_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fas_frame_scheduler.sv
// Bench for fas_frame_scheduler. Directed sample streams push the expected
// frames into exp_q. A monitor pops and compares them on each accepted
// transfer. A responder models the FFT engine, which returns a result 5
// cycles after each transfer, and the analysis unit, which finishes 3 cycles
// after ana_start.
module tb_fas_frame_scheduler;

    localparam int DW  = 16;
    localparam int NPT = 16;
    localparam int NF  = 64;
    localparam int W   = DW * NPT;

    logic          clk = 1'b0;
    logic          rst;
    logic          fir_valid;
    logic [DW-1:0] fir_d;
    logic          frm_valid;
    logic [W-1:0]  frm_data;
    logic          fft_ready;
    logic          fft_valid = 1'b0;
    logic          ana_start;
    logic          ana_done = 1'b0;
    logic          busy;
    logic          done;
    logic          overrun;
    logic [2:0]    dbg_state;
`ifdef FAS_SCHED_TIMEOUT_EN
    logic          timeout;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    int           due_q[$];
    int           cyc = 0;
    int           ana_due = -1;
    int           xfer_cnt = 0;
    int           ana_cnt = 0;
    int           res_cnt = 0;
    logic [W-1:0] acc_frm = '0;
    int           acc_n = 0;
    logic [W-1:0] f0;
    logic [W-1:0] f1;

    fas_frame_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .fir_valid (fir_valid),
        .fir_d     (fir_d),
        .frm_valid (frm_valid),
        .frm_data  (frm_data),
        .fft_ready (fft_ready),
        .fft_valid (fft_valid),
        .ana_start (ana_start),
        .ana_done  (ana_done),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun),
        .dbg_state (dbg_state)
`ifdef FAS_SCHED_TIMEOUT_EN
        , .timeout (timeout)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got still running expected finished");
        $fatal(1, "bench stalled");
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && frm_valid && fft_ready) begin
                xfer_cnt++;
                due_q.push_back(cyc + 5);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: got %0h expected no frame", frm_data);
                end else begin
                    chk("frame_data", frm_data, exp_q.pop_front());
                end
            end
            if (rst && ana_start) begin
                ana_cnt++;
                ana_due = cyc + 3;
                chk("ana_start_after_all_results", W'(res_cnt), W'(NF));
            end
        end
    end

    // FFT and analysis responders.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            fft_valid = 1'b0;
            ana_done  = 1'b0;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                void'(due_q.pop_front());
                fft_valid = 1'b1;
                res_cnt++;
            end
            if (ana_due == cyc) begin
                ana_done = 1'b1;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one sample for one cycle. When accepted is set, the bench models
    // the sample as stored and pushes each completed frame into exp_q.
    task automatic send(input logic [DW-1:0] v, input bit accepted);
        fir_valid = 1'b1;
        fir_d     = v;
        if (accepted) begin
            acc_frm[acc_n*DW +: DW] = v;
            acc_n++;
            if (acc_n == NPT) begin
                exp_q.push_back(acc_frm);
                acc_n = 0;
            end
        end
        @(posedge clk);
        #1;
        fir_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        fir_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        acc_n = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_frm_valid"}, W'(frm_valid), '0);
        chk({tag, "_frm_data"}, frm_data, '0);
        chk({tag, "_busy"}, W'(busy), '0);
        chk({tag, "_done"}, W'(done), '0);
        chk({tag, "_overrun"}, W'(overrun), '0);
        chk({tag, "_ana_start"}, W'(ana_start), '0);
        chk({tag, "_state"}, W'(dbg_state), '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b0;
        fir_valid = 1'b0;
        fir_d     = '0;
        fft_ready = 1'b0;
        idle(3);
        chk_all_zero("reset");
        rst = 1'b1;
        idle(2);

        // First frame latency and layout, with the FFT engine stalled.
        for (int i = 1; i <= 16; i++) send(DW'(i), 1'b1);
        f0 = exp_q[0];
        chk("frm_valid_not_yet", W'(frm_valid), '0);
        chk("busy_in_run", W'(busy), W'(1'b1));
        idle(1);
        chk("frm_valid_rises", W'(frm_valid), W'(1'b1));
        chk("frame0_sample0", W'(frm_data[15:0]), W'(16'h0001));
        chk("frame0_sample15", W'(frm_data[255:240]), W'(16'h0010));

        // The second bank fills while frame 0 is held.
        for (int i = 17; i <= 32; i++) send(DW'(i), 1'b1);
        f1 = exp_q[1];
        chk("no_overrun_two_banks", W'(overrun), '0);
        chk("frame0_held", frm_data, f0);

        // With both banks full, every further sample is dropped.
        for (int i = 33; i <= 48; i++) send(DW'(i), 1'b0);
        chk("overrun_set", W'(overrun), W'(1'b1));
        chk("frm_valid_held", W'(frm_valid), W'(1'b1));
        chk("frame0_held_after_drop", frm_data, f0);

        // Release one frame. The next full bank must follow immediately.
        fft_ready = 1'b1;
        idle(1);
        fft_ready = 1'b0;
        chk("frame1_presented_valid", W'(frm_valid), W'(1'b1));
        chk("frame1_presented_data", frm_data, f1);
        fft_ready = 1'b1;
        idle(1);
        fft_ready = 1'b0;
        chk("no_more_frames", W'(frm_valid), '0);
        chk("queue_empty_after_pair", W'(exp_q.size()), '0);
        chk("overrun_sticky", W'(overrun), W'(1'b1));
        idle(8);

        // A mid-run reset discards the partial frame.
        pulse_reset();
        chk("overrun_cleared", W'(overrun), '0);
        idle(5);
        xfer_cnt = 0;
        fft_ready = 1'b1;
        for (int i = 0; i < 600; i++) send(DW'(i * 3 + 7), 1'b1);
        rst = 1'b0;
        idle(1);
        chk_all_zero("midrun_reset");
        rst = 1'b1;
        chk("frames_before_reset", W'(xfer_cnt), W'(37));
        chk("queue_empty_before_reset", W'(exp_q.size()), '0);
        exp_q.delete();
        acc_n = 0;
        idle(10);

        // A fresh full run through to DONE.
        xfer_cnt = 0;
        ana_cnt  = 0;
        res_cnt  = 0;
        for (int i = 0; i < NF * NPT; i++) send(DW'(i), 1'b1);
        chk("busy_after_last_sample", W'(busy), W'(1'b1));
        for (int k = 0; k < 500 && !done; k++) idle(1);
        chk("done_reached", W'(done), W'(1'b1));
        chk("state_done", W'(dbg_state), W'(3'd4));
        chk("busy_low_in_done", W'(busy), '0);
        chk("frame_count", W'(xfer_cnt), W'(NF));
        chk("ana_start_count", W'(ana_cnt), W'(1));
        chk("no_overrun_full_run", W'(overrun), '0);
        chk("queue_empty_full_run", W'(exp_q.size()), '0);

        // In DONE, samples are ignored and do not raise overrun.
        fir_valid = 1'b1;
        fir_d     = 16'hbeef;
        idle(10);
        fir_valid = 1'b0;
        idle(2);
        chk("done_held", W'(done), W'(1'b1));
        chk("ignored_in_done_overrun", W'(overrun), '0);
        chk("ignored_in_done_frm_valid", W'(frm_valid), '0);
        chk("ignored_in_done_frames", W'(xfer_cnt), W'(NF));
        chk("single_ana_start", W'(ana_cnt), W'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
